// File: rtl/var_latency_pipe.sv
// Variable-latency payload delay line; a retime waits for the pipe to drain.
// Define VAR_LATENCY_PIPE_STATS_EN to add the accept_cnt/emit_cnt statistics outputs.
module var_latency_pipe #(
    parameter int MAX_DELAY  = 16,
    parameter int PIPE_WIDTH = 64,
    parameter int RST_DELAY  = 5,
    localparam int DW = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [PIPE_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [PIPE_WIDTH-1:0] out_data,
    input  logic [DW-1:0]         delay_sel,
    input  logic                  delay_load,
    input  logic                  flush,
    output logic [DW-1:0]         delay_cur,
    output logic [DW-1:0]         inflight,
    output logic                  drop_err
`ifdef VAR_LATENCY_PIPE_STATS_EN
    ,
    output logic [31:0]           accept_cnt,
    output logic [31:0]           emit_cnt
`endif
);

    typedef enum logic {S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    logic [DW-1:0]         r_pending;
    logic [DW-1:0]         r_delay_cur;
    logic [DW-1:0]         r_inflight;
    logic                  r_out_valid;
    logic [PIPE_WIDTH-1:0] r_out_data;
    logic                  r_drop_err;
    logic [MAX_DELAY-1:0]  r_valid;
    logic [PIPE_WIDTH-1:0] r_data [MAX_DELAY];

    logic                  w_accept;
    logic                  w_emit;
    logic                  w_tap_valid;
    logic [PIPE_WIDTH-1:0] w_tap_data;
    logic [MAX_DELAY-1:0]  w_valid_next;

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] sel);
        if (sel == '0)
            return DW'(1);
        if (32'(sel) > 32'(MAX_DELAY))
            return DW'(MAX_DELAY);
        return sel;
    endfunction

    assign in_ready  = (r_state == S_RUN);
    assign w_accept  = in_valid && (r_state == S_RUN) && !flush;
    assign w_emit    = w_tap_valid && !flush;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign delay_cur = r_delay_cur;
    assign inflight  = r_inflight;
    assign drop_err  = r_drop_err;

    // Valid bits die once they pass the active tap, so a later, longer delay
    // can never resurrect an entry that was already emitted.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DELAY; gi++) begin : g_stage
            logic w_prev_valid;
            if (gi == 0) begin : g_head
                assign w_prev_valid = w_accept;
            end else begin : g_body
                assign w_prev_valid = r_valid[gi-1];
            end
            assign w_valid_next[gi] = w_prev_valid && !flush && (DW'(gi) < r_delay_cur);
        end
    endgenerate

    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (r_delay_cur == DW'(i + 1)) begin
                w_tap_valid = r_valid[i];
                w_tap_data  = r_data[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < MAX_DELAY; i++)
                r_data[i] <= '0;
        end else begin
            r_valid  <= w_valid_next;
            r_data[0] <= in_data;
            for (int i = 1; i < MAX_DELAY; i++)
                r_data[i] <= r_data[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_pending   <= DW'(RST_DELAY);
            r_delay_cur <= DW'(RST_DELAY);
            r_inflight  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            r_out_data  <= w_tap_data;
            if (in_valid && r_state != S_RUN)
                r_drop_err <= 1'b1;

            if (flush)
                r_inflight <= '0;
            else if (w_accept && !w_emit)
                r_inflight <= r_inflight + 1'b1;
            else if (!w_accept && w_emit)
                r_inflight <= r_inflight - 1'b1;

            // A fresh load in DRAIN takes priority over applying the old pending value.
            case (r_state)
                S_RUN: begin
                    if (delay_load) begin
                        r_pending <= clamp_delay(delay_sel);
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (delay_load) begin
                        r_pending <= clamp_delay(delay_sel);
                    end else if (r_inflight == '0) begin
                        r_delay_cur <= r_pending;
                        r_state     <= S_RUN;
                    end
                end
            endcase
        end
    end

`ifdef VAR_LATENCY_PIPE_STATS_EN
    logic [31:0] r_accept_cnt;
    logic [31:0] r_emit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accept_cnt <= '0;
            r_emit_cnt   <= '0;
        end else begin
            if (w_accept)
                r_accept_cnt <= r_accept_cnt + 32'd1;
            if (w_emit)
                r_emit_cnt <= r_emit_cnt + 32'd1;
        end
    end

    assign accept_cnt = r_accept_cnt;
    assign emit_cnt   = r_emit_cnt;
`endif

endmodule

// File: tb/tb_var_latency_pipe.sv
// Self-checking bench for var_latency_pipe: vector table, hand-written corner
// sequences and a randomized run checked against a queue-based reference model.
module tb_var_latency_pipe;

    localparam int MAXD = 16;
    localparam int RSTD = 5;
    localparam int W    = 64;
    localparam int DW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [DW-1:0] delay_sel = '0;
    logic          delay_load = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] delay_cur;
    logic [DW-1:0] inflight;
    logic          drop_err;
`ifdef VAR_LATENCY_PIPE_STATS_EN
    logic [31:0]   accept_cnt;
    logic [31:0]   emit_cnt;
`endif

    var_latency_pipe #(
        .MAX_DELAY (MAXD),
        .PIPE_WIDTH(W),
        .RST_DELAY (RSTD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .delay_sel (delay_sel),
        .delay_load(delay_load),
        .flush     (flush),
        .delay_cur (delay_cur),
        .inflight  (inflight),
        .drop_err  (drop_err)
`ifdef VAR_LATENCY_PIPE_STATS_EN
        ,
        .accept_cnt(accept_cnt),
        .emit_cnt  (emit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each in-flight entry carries its remaining cycle count.
    typedef struct {
        logic [W-1:0] data;
        int           rem;
    } ent_t;
    ent_t         m_q[$];
    bit           m_run;
    int           m_delay;
    int           m_pend;
    bit           m_drop;
    bit           m_ov;
    logic [W-1:0] m_od;
    int unsigned  m_acc;
    int unsigned  m_emit;

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic [DW-1:0] sel;
        logic          ld;
        logic          fl;
        logic          e_ov;
        logic [W-1:0]  e_od;
        logic          e_rdy;
        logic [DW-1:0] e_dcur;
        logic [DW-1:0] e_infl;
    } vec_t;
    vec_t tbl[15];

    function automatic int mclamp(input int s);
        if (s == 0) return 1;
        if (s > MAXD) return MAXD;
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_run   = 1'b1;
        m_delay = RSTD;
        m_pend  = RSTD;
        m_drop  = 1'b0;
        m_ov    = 1'b0;
        m_acc   = 0;
        m_emit  = 0;
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        delay_load = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        #2;
        chk("rst_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_delay_cur", delay_cur, RSTD);
        chk("rst_drop_err", drop_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the model by one edge, compare everything.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic [DW-1:0] sel,
                        input logic ld, input logic fl);
        int pre_size;
        bit ready;
        in_valid   = iv;
        in_data    = d;
        delay_sel  = sel;
        delay_load = ld;
        flush      = fl;
        @(posedge clk);
        pre_size = m_q.size();
        ready    = m_run;
        if (iv && !ready) m_drop = 1'b1;
        m_ov = 1'b0;
        if (fl) begin
            m_q.delete();
        end else begin
            for (int i = 0; i < m_q.size(); i++) m_q[i].rem = m_q[i].rem - 1;
            if (m_q.size() > 0 && m_q[0].rem == 0) begin
                m_ov = 1'b1;
                m_od = m_q[0].data;
                m_q.delete(0);
                m_emit++;
            end
            if (iv && ready) begin
                m_q.push_back(ent_t'{d, m_delay});
                m_acc++;
            end
        end
        if (m_run) begin
            if (ld) begin
                m_pend = mclamp(int'(sel));
                m_run  = 1'b0;
            end
        end else if (ld) begin
            m_pend = mclamp(int'(sel));
        end else if (pre_size == 0) begin
            m_delay = m_pend;
            m_run   = 1'b1;
        end
        #1;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            $display("emit data=%0h delay=%0d t=%0t", m_od, m_delay, $time);
        end
        chk("in_ready", in_ready, m_run);
        chk("delay_cur", delay_cur, m_delay);
        chk("inflight", inflight, m_q.size());
        chk("drop_err", drop_err, m_drop);
`ifdef VAR_LATENCY_PIPE_STATS_EN
        chk("accept_cnt", accept_cnt, m_acc);
        chk("emit_cnt", emit_cnt, m_emit);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int emit_k[$];
        logic [W-1:0] emit_d[$];
        int seen;

        //            iv  data      sel ld fl  ov  odata     rdy dcur infl
        tbl[0]  = '{1'b1, 64'hA5, 5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd5,  5'd1};
        tbl[1]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd5,  5'd1};
        tbl[2]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd5,  5'd1};
        tbl[3]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd5,  5'd1};
        tbl[4]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd5,  5'd1};
        tbl[5]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b1, 64'hA5, 1'b1, 5'd5,  5'd0};
        tbl[6]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd5,  5'd0};
        tbl[7]  = '{1'b0, 64'h0,  5'd0,  1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 5'd5,  5'd0};
        tbl[8]  = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd1,  5'd0};
        tbl[9]  = '{1'b1, 64'h1,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd1,  5'd1};
        tbl[10] = '{1'b1, 64'h2,  5'd0,  1'b0, 1'b0, 1'b1, 64'h1,  1'b1, 5'd1,  5'd1};
        tbl[11] = '{1'b1, 64'h3,  5'd0,  1'b0, 1'b0, 1'b1, 64'h2,  1'b1, 5'd1,  5'd1};
        tbl[12] = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b1, 64'h3,  1'b1, 5'd1,  5'd0};
        tbl[13] = '{1'b0, 64'h0,  5'd21, 1'b1, 1'b0, 1'b0, 64'h0,  1'b0, 5'd1,  5'd0};
        tbl[14] = '{1'b0, 64'h0,  5'd0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 5'd16, 5'd0};

        #1;
        do_reset();

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].sel, tbl[i].ld, tbl[i].fl);
            $display("vec %0d: out_valid=%0b out_data=%0h ready=%0b delay_cur=%0d inflight=%0d",
                     i, out_valid, out_data, in_ready, delay_cur, inflight);
            chk("vec_out_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk("vec_out_data", out_data, tbl[i].e_od);
            chk("vec_ready", in_ready, tbl[i].e_rdy);
            chk("vec_delay_cur", delay_cur, tbl[i].e_dcur);
            chk("vec_inflight", inflight, tbl[i].e_infl);
        end

        // Back-to-back 1,2,3 at the clamped maximum latency.
        for (int k = 0; k < 28; k++) begin
            step(k < 3, 64'(k + 1), 5'd0, 1'b0, 1'b0);
            if (out_valid === 1'b1) begin
                emit_k.push_back(k);
                emit_d.push_back(out_data);
            end
        end
        $display("seq order: %0d emits at max latency", emit_k.size());
        chk("order_cnt", emit_k.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < emit_k.size()) begin
                chk("order_lat", emit_k[i], 16 + i);
                chk("order_data", emit_d[i], i + 1);
            end
        end

        // Retime to 2 with 4 entries in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 64'h100 + 64'(i), 5'd0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 5'd2, 1'b1, 1'b0);
        chk("drain_not_ready", in_ready, 0);
        for (int k = 0; k < 40 && in_ready !== 1'b1; k++) step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("drain_ready", in_ready, 1);
        chk("drain_dcur", delay_cur, 2);
        chk("drain_empty", inflight, 0);
        step(1'b1, 64'hBEEF, 5'd0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("lat2_early", out_valid, 0);
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("lat2_out", out_valid, 1);
        chk("lat2_data", out_data, 64'hBEEF);
        $display("seq retime: delay_cur=%0d", delay_cur);

        // Flush with 3 in flight, then an offer during DRAIN.
        step(1'b0, 64'h0, 5'd8, 1'b1, 1'b0);
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h200 + 64'(i), 5'd0, 1'b0, 1'b0);
        chk("pre_flush_infl", inflight, 3);
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b1);
        chk("flush_infl", inflight, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
            if (out_valid === 1'b1) seen++;
        end
        chk("flush_quiet", seen, 0);
        chk("drop_before", drop_err, 0);
        step(1'b0, 64'h0, 5'd8, 1'b1, 1'b0);
        step(1'b1, 64'hDEAD, 5'd0, 1'b0, 1'b0);
        chk("drop_set", drop_err, 1);
        for (int k = 0; k < 5; k++) step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("drop_sticky", drop_err, 1);
        $display("seq flush: drop_err=%0b", drop_err);

        // Reset in the middle of a DRAIN towards 9.
        step(1'b1, 64'h300, 5'd0, 1'b0, 1'b0);
        step(1'b1, 64'h301, 5'd0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 5'd9, 1'b1, 1'b0);
        chk("mid_drain", in_ready, 0);
        do_reset();
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("rst_drain_dcur", delay_cur, RSTD);
        chk("rst_drain_ready", in_ready, 1);
        $display("seq reset mid-drain: delay_cur=%0d", delay_cur);

`ifdef VAR_LATENCY_PIPE_STATS_EN
        step(1'b0, 64'h0, 5'd16, 1'b1, 1'b0);
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 90; i++) step(1'b1, 64'(i), 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 40 && inflight !== '0; k++) step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 64'(i), 5'd0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 5'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
        chk("stats_accept", accept_cnt, 100);
        chk("stats_emit", emit_cnt, 90);
        $display("seq stats: accept=%0d emit=%0d", accept_cnt, emit_cnt);
`endif

        do_reset();
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 9) < 7, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
